// File: rtl/hazard_stall_ctrl.sv
// Load-use, branch-operand and mul/div hazard detection for a 5-stage pipeline.
// Stall outputs are combinational; the load scoreboard, mul/div busy flag and stall counter are registered.
module hazard_stall_ctrl #(
  parameter int AW       = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [5:0]       id_op,
  input  logic [5:0]       id_func,
  input  logic [AW-1:0]    id_rs,
  input  logic [AW-1:0]    id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_valid,
  input  logic             ex_memread,
  input  logic             ex_regwrite,
  input  logic [AW-1:0]    ex_dst,
  input  logic             md_done,
  input  logic             flush,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             ctrl_pass,
  output logic             md_start,
  output logic             md_busy,
  output logic             stall_active,
  output logic [CNT_W-1:0] stall_cnt
);

  logic is_br_rsrt;
  logic is_br;
  logic is_md;
  logic rs_chk;
  logic rt_chk;
  logic ex_hit;
  logic ex_load_hit;
  logic ex_alu_hit;
  logic load_alu_hit;
  logic load_br_hit;
  logic md_hazard;
  logic stall;
  logic unused_func_bits;

  logic             slot_v_reg   [1:LOAD_LAT];
  logic [AW-1:0]    slot_d_reg   [1:LOAD_LAT];
  logic             slot_hit     [1:LOAD_LAT];
  logic             md_busy_reg;
  logic [CNT_W-1:0] stall_cnt_reg;

  // Decode: branches resolved in ID versus everything else.
  assign is_br_rsrt = (id_op[5:1] == 5'b00010);
  assign is_br      = is_br_rsrt
                    | (id_op[5:2] == 4'b0001)
                    | (id_op == 6'b000001)
                    | ((id_op == 6'b000000) & (id_func[5:3] == 3'b001));
  assign is_md      = (id_op == 6'b000000)
                    & ((id_func[5:3] == 3'b010) | (id_func[5:3] == 3'b011));
  assign unused_func_bits = ^id_func[2:0];

  // rs-only branches ignore rt even if the decoder flags it; $0 never hazards.
  assign rs_chk = id_use_rs & (id_rs != '0);
  assign rt_chk = id_use_rt & (id_rt != '0) & (is_br_rsrt | ~is_br);

  assign ex_hit      = ex_valid & (ex_dst != '0)
                     & ((rs_chk & (id_rs == ex_dst)) | (rt_chk & (id_rt == ex_dst)));
  assign ex_load_hit = ex_hit & ex_memread;
  assign ex_alu_hit  = ex_hit & ex_regwrite & ~ex_memread;

  for (genvar gi = 1; gi <= LOAD_LAT; gi++) begin : g_slot
    assign slot_hit[gi] = slot_v_reg[gi]
                        & ((rs_chk & (id_rs == slot_d_reg[gi]))
                         | (rt_chk & (id_rt == slot_d_reg[gi])));
  end

  // ALU consumers wait until age LOAD_LAT; branches also wait out that age.
  always_comb begin
    load_alu_hit = ex_load_hit;
    load_br_hit  = ex_load_hit;
    for (int a = 1; a <= LOAD_LAT; a++) begin
      if (slot_hit[a]) begin
        load_br_hit = 1'b1;
        if (a < LOAD_LAT) load_alu_hit = 1'b1;
      end
    end
  end

  assign md_hazard = is_md & md_busy_reg & ~md_done;
  assign stall     = id_valid & ~flush
                   & ((~is_br & load_alu_hit)
                    | (is_br & (load_br_hit | ex_alu_hit))
                    | md_hazard);

  assign pc_write     = ~stall;
  assign if_id_write  = ~stall;
  assign ctrl_pass    = ~stall;
  assign stall_active = stall;
  assign md_start     = id_valid & ~flush & is_md & ~stall;
  assign md_busy      = md_busy_reg;
  assign stall_cnt    = stall_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= LOAD_LAT; k++) begin
        slot_v_reg[k] <= 1'b0;
        slot_d_reg[k] <= '0;
      end
    end else begin
      slot_v_reg[1] <= ex_valid & ex_memread & (ex_dst != '0);
      slot_d_reg[1] <= ex_dst;
      for (int k = 2; k <= LOAD_LAT; k++) begin
        slot_v_reg[k] <= slot_v_reg[k-1];
        slot_d_reg[k] <= slot_d_reg[k-1];
      end
    end
  end

  // A new issue wins over a completion landing in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_busy_reg <= 1'b0;
    end else if (md_start) begin
      md_busy_reg <= 1'b1;
    end else if (md_done) begin
      md_busy_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (stall && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 SHALL have parameter AW, default 5, register-address width.
REQ-002 SHALL have parameter LOAD_LAT, default 1, range 1..4: cycles after a load leaves EX before its data is forwardable to EX.
REQ-003 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports id_valid, input, 1; id_op and id_func, input, 6 each; id_rs and id_rt, input, AW: the instruction in ID.
REQ-007 SHALL have ports id_use_rs and id_use_rt, input, 1 each: decoder flags marking a source as read.
REQ-008 SHALL have ports ex_valid, ex_memread and ex_regwrite, input, 1 each, plus ex_dst, input, AW: the instruction in EX (regwrite active-high).
REQ-009 SHALL have ports md_done and flush, input, 1 each: multiply/divide completion, and ID squash on redirect.
REQ-010 SHALL have ports pc_write, if_id_write and ctrl_pass, output, 1 each: 1 = advance, 0 = hold PC/IF-ID and inject an EX bubble.
REQ-011 SHALL have ports md_start, output, 1 (issue pulse to the mul/div unit), and md_busy, output, 1.
REQ-012 SHALL have ports stall_active, output, 1, and stall_cnt, output, CNT_W.

Function
REQ-013 SHALL classify ID as an early branch when id_op[5:1]=00010 (beq/bne, rs+rt), id_op[5:2]=0001 (rs only), id_op=000001 (rs only) or id_op=0 with id_func[5:3]=001 (jr/jalr, rs only); all other instructions are ALU consumers.
REQ-014 SHALL classify ID as a mul/div op when id_op=0 and id_func[5:3] is 010 or 011.
REQ-015 SHALL keep a load scoreboard of LOAD_LAT registered slots (ages 1..LOAD_LAT), each holding valid+dst; EX itself is age 0.
REQ-016 SHALL shift every cycle: slot1 <= {ex_valid & ex_memread & (ex_dst!=0), ex_dst}; slot[k+1] <= slot[k]; the oldest slot is dropped.
REQ-017 SHALL flag a match when a used id_rs/id_rt equals the slot dst; register 0 never matches.
REQ-018 SHALL stall an ALU consumer on a load match at age a < LOAD_LAT.
REQ-019 SHALL stall an early branch on a load match at age a <= LOAD_LAT.
REQ-020 SHALL stall an early branch on a non-load match at age 0 (ex_regwrite=1, ex_memread=0).
REQ-021 SHALL set md_busy on md_start and clear it on md_done; simultaneous md_start and md_done SHALL leave md_busy=1.
REQ-022 SHALL stall a mul/div op in ID while md_busy=1 and md_done=0.
REQ-023 SHALL pulse md_start for one cycle only when a valid mul/div op is in ID, unstalled and not flushed.
REQ-024 SHALL compute stall = id_valid & ~flush & (any REQ-018..020 or REQ-022 condition); outputs SHALL be combinational, with pc_write = if_id_write = ctrl_pass = ~stall.
REQ-025 SHALL drive stall_active = stall and increment stall_cnt each stalled cycle, saturating at all-ones without wrapping.
REQ-026 SHALL have flush override all stall conditions in the same cycle.
REQ-027 SHALL have id_valid=0 produce no stall and no md_start.

Reset
REQ-028 SHALL, while rst_n=0, clear all scoreboard slots, md_busy and stall_cnt immediately, independent of clk.
REQ-029 SHALL, after reset and with id_valid=0, drive pc_write=if_id_write=ctrl_pass=1, md_start=0 and stall_active=0.
REQ-030 SHALL, on reset asserted mid-stall or mid-mul/div, abandon the pending state; the first post-reset cycle SHALL see no stall.

Verification
REQ-031 LOAD_LAT=1, lw $5 in EX, add using rs=5 in ID -> 1 stall cycle (outputs 0), then 1, stall_cnt=1.
REQ-032 LOAD_LAT=2, lw $5 in EX, beq rs=5 in ID -> 3 stall cycles, stall_cnt=3; with ALU consumer -> 2 stall cycles.
REQ-033 add $7 in EX, bne rt=7 in ID -> 1 stall; same with ex_dst=0 -> no stall.
REQ-034 Issue div, then mflo in ID; md_done arrives 5 cycles later -> stalls until md_done; md_start pulses once; md_start+md_done in the same cycle -> md_busy stays 1.
REQ-035 Stall in progress plus flush=1 -> outputs 1 that cycle; stall_cnt preloaded to all-ones, one more stall -> stays all-ones.
REQ-036 rst_n low mid-load-stall -> slots cleared, outputs 1, stall_cnt=0 before the next clk edge.
